// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues one request per load/store over a
// req/ack bus, stalls the pipeline while it is outstanding, flags misalignment and timeouts.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdataValid,
    output logic        misaligned,
    output logic        timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    localparam logic [15:0] LP_LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [15:0] r_waitCnt;
    logic        r_memReq;
    logic        r_memWe;
    logic [31:0] r_memAddr;
    logic [31:0] r_memWdata;
    logic [31:0] r_rdata;
    logic        r_rdataValid;
    logic        r_misaligned;
    logic        r_timeout;

    logic        w_pending;
    logic        w_aligned;

    assign w_pending = memRead | memWrite;
    assign w_aligned = (addr[1:0] == 2'b00);

    // Gated by reset so an access in flight releases the pipeline immediately.
    assign stall = ~reset & (((r_state == S_IDLE) & w_pending & w_aligned) | (r_state == S_REQ));

    assign memReq     = r_memReq;
    assign memWe      = r_memWe;
    assign memAddr    = r_memAddr;
    assign memWdata   = r_memWdata;
    assign rdata      = r_rdata;
    assign rdataValid = r_rdataValid;
    assign misaligned = r_misaligned;
    assign timeout    = r_timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_waitCnt    <= '0;
            r_memReq     <= 1'b0;
            r_memWe      <= 1'b0;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_rdata      <= '0;
            r_rdataValid <= 1'b0;
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_rdataValid <= 1'b0;
            r_misaligned <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pending && w_aligned) begin
                        r_state    <= S_REQ;
                        r_memReq   <= 1'b1;
                        r_memWe    <= memWrite;
                        r_memAddr  <= {addr[31:2], 2'b00};
                        r_memWdata <= wdata;
                        r_waitCnt  <= '0;
                    end else if (w_pending) begin
                        r_misaligned <= 1'b1;
                    end
                end
                S_REQ: begin
                    // An ack arriving on the final wait cycle takes priority over the timeout.
                    if (memAck) begin
                        r_state  <= S_DONE;
                        r_memReq <= 1'b0;
                        if (!r_memWe) begin
                            r_rdata      <= memRdata;
                            r_rdataValid <= 1'b1;
                        end
                    end else if (r_waitCnt == LP_LAST_WAIT) begin
                        r_state      <= S_DONE;
                        r_memReq     <= 1'b0;
                        r_timeout    <= 1'b1;
                        r_rdata      <= '0;
                        r_rdataValid <= ~r_memWe;
                    end else begin
                        r_waitCnt <= r_waitCnt + 16'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: expected load data is queued at issue
// and popped whenever rdataValid pulses; bus timing is checked cycle by cycle.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memAck = 1'b0;
    logic [31:0] memRdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdataValid;
    logic        misaligned;
    logic        timeout;

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_valid = 0;
    logic [31:0] exp_q[$];

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .memRead(memRead), .memWrite(memWrite),
        .addr(addr), .wdata(wdata), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWdata(memWdata), .memAck(memAck),
        .memRdata(memRdata), .stall(stall), .rdata(rdata),
        .rdataValid(rdataValid), .misaligned(misaligned), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!reset && rdataValid) begin
            n_valid++;
            if (exp_q.size() == 0) check("rdata_unexpected", 32'(rdataValid), 32'd0);
            else check("rdata", rdata, exp_q.pop_front());
        end
    end

    // Presents one instruction, acks on REQ cycle ack_at (0 = never) and holds it until stall drops.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input int ack_at, input logic [31:0] mrd,
                             output int ns, output int nr);
        bit done = 0;
        ns = 0;
        nr = 0;
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; addr = a; wdata = wd; memRdata = mrd;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (memReq) begin
                nr++;
                check("memAddr", memAddr, a);
                check("memWe", 32'(memWe), 32'(wr));
                if (wr) check("memWdata", memWdata, wd);
            end
            memAck = memReq && (nr == ack_at);
            if (stall) ns++;
            else begin
                done = 1;
                break;
            end
        end
        if (!done) check("access_bound", 32'd0, 32'd1);
        @(posedge clk); #1;
        memRead = 0; memWrite = 0; memAck = 0;
    endtask

    initial begin
        int ns, nr, v0;

        // Reset state, with an aligned load pending to prove stall is gated.
        memRead = 1; addr = 32'h0;
        #12;
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_flags", {29'd0, rdataValid, misaligned, timeout}, 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        memRead = 0;
        @(posedge clk); #1 reset = 0;

        // Load with ack on third REQ cycle.
        exp_q.push_back(32'hCAFEF00D);
        v0 = n_valid;
        do_access(1, 0, 32'h100, 32'h0, 3, 32'hCAFEF00D, ns, nr);
        check("ld_req_cycles", 32'(nr), 32'd3);
        check("ld_stall_cycles", 32'(ns), 32'd4);
        check("ld_valid_pulses", 32'(n_valid - v0), 32'd1);

        // Store acked in first REQ cycle.
        v0 = n_valid;
        do_access(0, 1, 32'h204, 32'h12345678, 1, 32'hFFFFFFFF, ns, nr);
        check("st_req_cycles", 32'(nr), 32'd1);
        check("st_stall_cycles", 32'(ns), 32'd2);
        check("st_no_valid", 32'(n_valid - v0), 32'd0);
        check("st_rdata_kept", rdata, 32'hCAFEF00D);

        // Misaligned load.
        do_access(1, 0, 32'h102, 32'h0, 1, 32'h0, ns, nr);
        check("mis_stall", 32'(ns), 32'd0);
        check("mis_req", 32'(nr), 32'd0);
        @(negedge clk);
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_no_req", 32'(memReq), 32'd0);
        @(negedge clk);
        check("mis_pulse_end", 32'(misaligned), 32'd0);

        // Both commands: treated as a write.
        v0 = n_valid;
        do_access(1, 1, 32'h8, 32'h0BADBEEF, 2, 32'h55555555, ns, nr);
        check("rw_stall_cycles", 32'(ns), 32'd3);
        check("rw_no_valid", 32'(n_valid - v0), 32'd0);

        // Spurious ack while idle.
        v0 = n_valid;
        @(posedge clk); #1 memAck = 1;
        @(posedge clk); #1 memAck = 0;
        @(negedge clk);
        check("spur_req", 32'(memReq), 32'd0);
        check("spur_stall", 32'(stall), 32'd0);
        check("spur_valid", 32'(n_valid - v0), 32'd0);

        // Timeout: ack never arrives.
        check("pre_timeout", 32'(timeout), 32'd0);
        exp_q.push_back(32'h0);
        v0 = n_valid;
        do_access(1, 0, 32'h40, 32'h0, 0, 32'hDEADBEEF, ns, nr);
        check("to_req_cycles", 32'(nr), 32'd4);
        check("to_stall_cycles", 32'(ns), 32'd5);
        check("to_valid_pulses", 32'(n_valid - v0), 32'd1);
        check("to_sticky", 32'(timeout), 32'd1);

        // Following load completes normally; timeout stays set.
        exp_q.push_back(32'h13572468);
        do_access(1, 0, 32'h44, 32'h0, 2, 32'h13572468, ns, nr);
        check("after_to_req", 32'(nr), 32'd2);
        check("after_to_sticky", 32'(timeout), 32'd1);

        // Ack on the last allowed cycle wins over the timeout (checked after a reset clears it).
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        check("rst_clears_to", 32'(timeout), 32'd0);
        exp_q.push_back(32'h2468ACE0);
        do_access(1, 0, 32'h80, 32'h0, 4, 32'h2468ACE0, ns, nr);
        check("edge_ack_req", 32'(nr), 32'd4);
        check("edge_ack_no_to", 32'(timeout), 32'd0);

        // Reset on the 2nd REQ cycle of a load.
        v0 = n_valid;
        @(posedge clk); #1 memRead = 1; addr = 32'h300;
        @(posedge clk); #1;
        check("mid_req_on", 32'(memReq), 32'd1);
        @(posedge clk); #1;
        reset = 1;
        #1;
        check("mid_rst_req", 32'(memReq), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        memRead = 0;
        @(posedge clk); #1 reset = 0;
        do_access(0, 1, 32'h304, 32'hA5A5A5A5, 2, 32'h0, ns, nr);
        check("post_rst_st_stall", 32'(ns), 32'd3);
        check("post_rst_no_valid", 32'(n_valid - v0), 32'd0);

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
        $fatal(1, "simulation time limit");
    end

endmodule
